// File: rtl/dca_matrix_lsu_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// dca_matrix_lsu_dispatch_pkg
//   Shared definitions for the DCA matrix LSU instruction dispatcher:
//   FSM state encoding, inst FIFO word field offsets, width helpers and
//   error-flag bit indices (the error flags exist only when the dispatcher is
//   built with DCA_MATRIX_LSU_DISPATCH_ERROR_EN defined).
// -----------------------------------------------------------------------------
package dca_matrix_lsu_dispatch_pkg;

    // Dispatcher FSM states
    localparam logic [1:0] ST_FETCH      = 2'd0;
    localparam logic [1:0] ST_ISSUE      = 2'd1;
    localparam logic [1:0] ST_FENCE_WAIT = 2'd2;
    localparam logic [1:0] ST_CLEAR_WAIT = 2'd3;

    // Sticky error flag bit positions
    localparam int ERR_FINISH_AT_ZERO   = 0;
    localparam int ERR_BAD_CH           = 1;
    localparam int ERR_WREADY_NO_WVALID = 2;
    localparam int NUM_ERR              = 3;

    // Channel index width; at least one bit even for a single channel
    function automatic int calc_bw_ch(input int num_channel);
        return (num_channel <= 1) ? 1 : $clog2(num_channel);
    endfunction

    // Counter width able to hold 0..max_outstanding
    function automatic int calc_bw_cnt(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

    // Inst FIFO word layout: {fence, ch_idx, payload}
    function automatic int ch_lsb(input int bw_lsu_inst);
        return bw_lsu_inst;
    endfunction

    function automatic int fence_bit(input int bw_lsu_inst, input int bw_ch);
        return bw_lsu_inst + bw_ch;
    endfunction

endpackage

// File: rtl/dca_matrix_lsu_outstanding_counter.sv
// -----------------------------------------------------------------------------
// dca_matrix_lsu_outstanding_counter
//   Per-channel count of issued-but-not-executed LSU instructions.
//   Ports:
//     clk, rstnn  : clock, synchronous active-low reset
//     inc         : instruction handshake on this channel
//     dec         : execute_finish pulse from this channel's LSU
//     count       : current outstanding count
//     full        : count == MAX_OUTSTANDING
//     zero        : count == 0
// -----------------------------------------------------------------------------
module dca_matrix_lsu_outstanding_counter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int BW_CNT          = 3
) (
    input  logic              clk,
    input  logic              rstnn,
    input  logic              inc,
    input  logic              dec,
    output logic [BW_CNT-1:0] count,
    output logic              full,
    output logic              zero
);

    localparam logic [BW_CNT-1:0] MAX_CNT = BW_CNT'(MAX_OUTSTANDING);

    logic inc_eff;
    logic dec_eff;

    // A finish with nothing outstanding is spurious and ignored; an increment
    // at the ceiling cannot be produced by the dispatcher but is blocked anyway.
    assign dec_eff = dec && !zero;
    assign inc_eff = inc && !full;

    assign full = (count == MAX_CNT);
    assign zero = (count == '0);

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            count <= '0;
        end else if (inc_eff && !dec_eff) begin
            count <= count + 1'b1;
        end else if (dec_eff && !inc_eff) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/dca_matrix_lsu_inst_dispatcher.sv
// -----------------------------------------------------------------------------
// dca_matrix_lsu_inst_dispatcher
//   Pops tagged instructions {fence, ch_idx, payload} from the control inst
//   FIFO and routes the payload to the addressed LSU. Tracks outstanding
//   instructions per channel and implements fence retirement and
//   drain-on-clear.
//   Ports:
//     clk, rstnn                         : clock, synchronous active-low reset
//     control_rmx_inst_fifo_rready/rdata : FIFO head valid / head word
//     control_rmx_inst_fifo_rrequest     : pop head this cycle
//     control_rmx_operation_finish       : one-cycle pulse per retired fence
//     control_rmx_clear_request          : level drain request
//     control_rmx_clear_finish           : one-cycle pulse when drained
//     lsu_inst_wvalid/wdata/wready       : per-channel instruction handshake
//     lsu_inst_execute_finish            : per-channel completion pulses
//     lsu_busy                           : per-channel LSU busy
//     outstanding                        : per-channel counters, packed
//     all_idle                           : counters 0, no busy, in FETCH
//     error_flags (optional)             : sticky {wready w/o wvalid,
//                                          bad ch_idx, finish at zero}
//   Build option: define DCA_MATRIX_LSU_DISPATCH_ERROR_EN to add error_flags.
// -----------------------------------------------------------------------------
module dca_matrix_lsu_inst_dispatcher
    import dca_matrix_lsu_dispatch_pkg::*;
#(
    parameter  int NUM_CHANNEL     = 3,
    parameter  int BW_LSU_INST     = 64,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int BW_CH           = calc_bw_ch(NUM_CHANNEL),
    localparam int BW_CNT          = calc_bw_cnt(MAX_OUTSTANDING),
    localparam int BW_INST         = BW_LSU_INST + BW_CH + 1
) (
    input  logic                               clk,
    input  logic                               rstnn,
    input  logic                               control_rmx_inst_fifo_rready,
    input  logic [BW_INST-1:0]                 control_rmx_inst_fifo_rdata,
    output logic                               control_rmx_inst_fifo_rrequest,
    output logic                               control_rmx_operation_finish,
    input  logic                               control_rmx_clear_request,
    output logic                               control_rmx_clear_finish,
    output logic [NUM_CHANNEL-1:0]             lsu_inst_wvalid,
    output logic [NUM_CHANNEL*BW_LSU_INST-1:0] lsu_inst_wdata,
    input  logic [NUM_CHANNEL-1:0]             lsu_inst_wready,
    input  logic [NUM_CHANNEL-1:0]             lsu_inst_execute_finish,
    input  logic [NUM_CHANNEL-1:0]             lsu_busy,
    output logic [NUM_CHANNEL*BW_CNT-1:0]      outstanding,
    output logic                               all_idle
`ifdef DCA_MATRIX_LSU_DISPATCH_ERROR_EN
    ,
    output logic [NUM_ERR-1:0]                 error_flags
`endif
);

    localparam int             FENCE_BIT = fence_bit(BW_LSU_INST, BW_CH);
    localparam int             CH_LSB    = ch_lsb(BW_LSU_INST);
    localparam logic [BW_CH:0] NUM_CH_W  = (BW_CH+1)'(NUM_CHANNEL);

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [BW_LSU_INST-1:0] issue_payload_p1;
    logic [BW_CH-1:0]       issue_ch_p1;
    logic                   op_finish_q;

    logic                   head_fence;
    logic [BW_CH-1:0]       head_ch;
    logic [BW_LSU_INST-1:0] head_payload;
    logic                   head_ch_ok;
    logic                   head_ch_full;

    logic                   latch_head;
    logic                   fence_retire;
    logic                   bad_drop;
    logic                   cnt_idle;

    logic [NUM_CHANNEL-1:0] inc_vec;
    logic [NUM_CHANNEL-1:0] full_vec;
    logic [NUM_CHANNEL-1:0] zero_vec;
    logic [BW_CNT-1:0]      count_arr [NUM_CHANNEL];

    assign head_fence   = control_rmx_inst_fifo_rdata[FENCE_BIT];
    assign head_ch      = control_rmx_inst_fifo_rdata[CH_LSB +: BW_CH];
    assign head_payload = control_rmx_inst_fifo_rdata[BW_LSU_INST-1:0];
    assign head_ch_ok   = ({1'b0, head_ch} < NUM_CH_W);

    // Fences and clears wait for every channel to drain and every LSU to idle
    assign cnt_idle = (&zero_vec) && !(|lsu_busy);
    assign all_idle = cnt_idle && (state_q == ST_FETCH);

    always_comb begin
        head_ch_full = 1'b0;
        for (int c = 0; c < NUM_CHANNEL; c++) begin
            if (head_ch == BW_CH'(c)) head_ch_full = full_vec[c];
        end
    end

    // Exactly one wvalid bit while in ISSUE; idle slices read as zero
    always_comb begin
        lsu_inst_wvalid = '0;
        lsu_inst_wdata  = '0;
        for (int c = 0; c < NUM_CHANNEL; c++) begin
            if ((state_q == ST_ISSUE) && (issue_ch_p1 == BW_CH'(c))) begin
                lsu_inst_wvalid[c]                          = 1'b1;
                lsu_inst_wdata[c*BW_LSU_INST +: BW_LSU_INST] = issue_payload_p1;
            end
        end
    end

    assign inc_vec = lsu_inst_wvalid & lsu_inst_wready;

    always_comb begin
        state_d                        = state_q;
        control_rmx_inst_fifo_rrequest = 1'b0;
        control_rmx_clear_finish       = 1'b0;
        latch_head                     = 1'b0;
        fence_retire                   = 1'b0;
        bad_drop                       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (control_rmx_clear_request) begin
                    state_d = ST_CLEAR_WAIT;
                end else if (control_rmx_inst_fifo_rready) begin
                    if (head_fence) begin
                        if (cnt_idle) begin
                            control_rmx_inst_fifo_rrequest = 1'b1;
                            fence_retire                   = 1'b1;
                        end else begin
                            state_d = ST_FENCE_WAIT;
                        end
                    end else if (!head_ch_ok) begin
                        control_rmx_inst_fifo_rrequest = 1'b1;
                        bad_drop                       = 1'b1;
                    end else if (!head_ch_full) begin
                        control_rmx_inst_fifo_rrequest = 1'b1;
                        latch_head                     = 1'b1;
                        state_d                        = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (|inc_vec) state_d = ST_FETCH;
            end
            ST_FENCE_WAIT: begin
                // The fence is still the FIFO head, so it is popped here
                if (cnt_idle) begin
                    control_rmx_inst_fifo_rrequest = 1'b1;
                    fence_retire                   = 1'b1;
                    state_d                        = ST_FETCH;
                end
            end
            default: begin
                if (cnt_idle) begin
                    control_rmx_clear_finish = 1'b1;
                    state_d                  = ST_FETCH;
                end
            end
        endcase
    end

    // ---- stage p0 -> p1: FIFO head captured for the ISSUE cycle ----
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state_q     <= ST_FETCH;
            op_finish_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_finish_q <= fence_retire;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_head) begin
            issue_payload_p1 <= head_payload;
            issue_ch_p1      <= head_ch;
        end
    end

    assign control_rmx_operation_finish = op_finish_q;

    for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_ch
        dca_matrix_lsu_outstanding_counter #(
            .MAX_OUTSTANDING(MAX_OUTSTANDING),
            .BW_CNT         (BW_CNT)
        ) u_cnt (
            .clk  (clk),
            .rstnn(rstnn),
            .inc  (inc_vec[c]),
            .dec  (lsu_inst_execute_finish[c]),
            .count(count_arr[c]),
            .full (full_vec[c]),
            .zero (zero_vec[c])
        );
        assign outstanding[c*BW_CNT +: BW_CNT] = count_arr[c];
    end

`ifdef DCA_MATRIX_LSU_DISPATCH_ERROR_EN
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            error_flags <= '0;
        end else begin
            if (|(lsu_inst_execute_finish & zero_vec))
                error_flags[ERR_FINISH_AT_ZERO] <= 1'b1;
            if (bad_drop)
                error_flags[ERR_BAD_CH] <= 1'b1;
            if (|(lsu_inst_wready & ~lsu_inst_wvalid))
                error_flags[ERR_WREADY_NO_WVALID] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dca_matrix_lsu_inst_dispatcher.sv
module tb_dca_matrix_lsu_inst_dispatcher;

    localparam int NCH  = 3;
    localparam int BWP  = 64;
    localparam int MAXO = 4;
    localparam int BWC  = 3;
    localparam int BWI  = BWP + 2 + 1;

    logic             clk = 1'b0;
    logic             rstnn;
    logic             rready;
    logic [BWI-1:0]   rdata;
    logic             rrequest;
    logic             op_finish;
    logic             clear_req;
    logic             clear_finish;
    logic [NCH-1:0]   wvalid;
    logic [NCH*BWP-1:0] wdata;
    logic [NCH-1:0]   wready;
    logic [NCH-1:0]   efin;
    logic [NCH-1:0]   busy;
    logic [NCH*BWC-1:0] outstanding;
    logic             all_idle;
`ifdef DCA_MATRIX_LSU_DISPATCH_ERROR_EN
    logic [2:0]       error_flags;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dca_matrix_lsu_inst_dispatcher #(
        .NUM_CHANNEL    (NCH),
        .BW_LSU_INST    (BWP),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk                            (clk),
        .rstnn                          (rstnn),
        .control_rmx_inst_fifo_rready   (rready),
        .control_rmx_inst_fifo_rdata    (rdata),
        .control_rmx_inst_fifo_rrequest (rrequest),
        .control_rmx_operation_finish   (op_finish),
        .control_rmx_clear_request      (clear_req),
        .control_rmx_clear_finish       (clear_finish),
        .lsu_inst_wvalid                (wvalid),
        .lsu_inst_wdata                 (wdata),
        .lsu_inst_wready                (wready),
        .lsu_inst_execute_finish        (efin),
        .lsu_busy                       (busy),
        .outstanding                    (outstanding),
        .all_idle                       (all_idle)
`ifdef DCA_MATRIX_LSU_DISPATCH_ERROR_EN
        ,
        .error_flags                    (error_flags)
`endif
    );

    typedef struct {
        logic [1:0]  ch;
        logic [63:0] payload;
        logic [2:0]  fin;
        logic [2:0]  exp_wvalid;
        logic [8:0]  exp_out;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic f, input logic [1:0] ch, input logic [63:0] p);
        rready = 1'b1;
        rdata  = {f, ch, p};
    endtask

    task automatic issue(input logic [1:0] ch, input logic [63:0] p);
        push(1'b0, ch, p);
        #1 chk("issue_rrequest", rrequest, 1);
        cyc();
        rready = 1'b0;
        #1 chk("issue_wvalid", wvalid, 3'b001 << ch);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [191:0] exp_wdata;
        logic         seen;

        //            ch     payload                 fin     wvalid  {ch2,ch1,ch0}
        vecs[0] = '{2'd1, 64'hA5,                 3'b000, 3'b010, {3'd0, 3'd1, 3'd0}};
        vecs[1] = '{2'd0, 64'h1234,               3'b000, 3'b001, {3'd0, 3'd1, 3'd1}};
        vecs[2] = '{2'd2, 64'hDEADBEEF_00000001,  3'b010, 3'b100, {3'd1, 3'd0, 3'd1}};
        vecs[3] = '{2'd3, 64'hFF,                 3'b000, 3'b000, {3'd1, 3'd0, 3'd1}};
        vecs[4] = '{2'd2, 64'h55,                 3'b000, 3'b100, {3'd2, 3'd0, 3'd1}};
        vecs[5] = '{2'd2, 64'h66,                 3'b100, 3'b100, {3'd2, 3'd0, 3'd1}};
        vecs[6] = '{2'd1, 64'h77,                 3'b001, 3'b010, {3'd2, 3'd1, 3'd0}};
        vecs[7] = '{2'd0, 64'h88,                 3'b010, 3'b001, {3'd2, 3'd0, 3'd1}};
        vecs[8] = '{2'd0, 64'h99,                 3'b010, 3'b001, {3'd2, 3'd0, 3'd2}};

        rstnn = 1'b0; rready = 1'b0; rdata = '0; clear_req = 1'b0;
        wready = 3'b111; efin = '0; busy = '0;
        cyc(); cyc();
        chk("rst_rrequest", rrequest, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_op_finish", op_finish, 0);
        chk("rst_clear_finish", clear_finish, 0);
        chk("rst_all_idle", all_idle, 1);
        rstnn = 1'b1;
        cyc();

        // Table: pop at N, wvalid at N+1, counter updated at N+2
        for (int i = 0; i < 9; i++) begin
            push(1'b0, vecs[i].ch, vecs[i].payload);
            #1 chk($sformatf("vec%0d_rrequest", i), rrequest, 1);
            cyc();
            rready = 1'b0;
            efin   = vecs[i].fin;
            exp_wdata = '0;
            for (int c = 0; c < NCH; c++)
                if (vecs[i].exp_wvalid[c]) exp_wdata[c*BWP +: BWP] = vecs[i].payload;
            #1 chk($sformatf("vec%0d_wvalid", i), wvalid, vecs[i].exp_wvalid);
            chk($sformatf("vec%0d_wdata", i), wdata, exp_wdata);
            cyc();
            efin = '0;
            #1 chk($sformatf("vec%0d_outstanding", i), outstanding, vecs[i].exp_out);
        end

        // Drain ch2 (2) and ch0 (2)
        efin = 3'b101;
        cyc(); cyc();
        efin = '0;
        #1 chk("drain_outstanding", outstanding, 0);
        chk("drain_all_idle", all_idle, 1);

        // Counter ceiling: 4 issued, 5th stalls until a finish frees a slot
        for (int k = 0; k < 4; k++) issue(2'd0, 64'(k + 16));
        chk("max_count", outstanding[2:0], 4);
        push(1'b0, 2'd0, 64'hE5);
        #1 chk("max_stall0", rrequest, 0);
        cyc();
        chk("max_stall1", rrequest, 0);
        efin = 3'b001;
        #1 chk("max_stall2", rrequest, 0);
        cyc();
        efin = '0;
        #1 chk("max_release_rrequest", rrequest, 1);
        cyc();
        rready = 1'b0;
        #1 chk("max_release_wdata", wdata[63:0], 64'hE5);
        cyc();
        #1 chk("max_recount", outstanding[2:0], 4);

        // Fence with 2 outstanding on ch0, then LSU busy holds it
        efin = 3'b001;
        cyc(); cyc();
        efin = '0;
        #1 chk("fence_pre_count", outstanding[2:0], 2);
        push(1'b1, 2'd0, 64'h0);
        #1 chk("fence_hold0", rrequest, 0);
        cyc();
        busy = 3'b001;
        efin = 3'b001;
        #1 chk("fence_hold1", rrequest, 0);
        cyc(); cyc();
        efin = '0;
        #1 chk("fence_busy_hold", rrequest, 0);
        chk("fence_busy_all_idle", all_idle, 0);
        chk("fence_no_early_finish", op_finish, 0);
        busy = '0;
        #1 chk("fence_pop", rrequest, 1);
        cyc();
        rready = 1'b0;
        #1 chk("fence_op_finish", op_finish, 1);
        cyc();
        chk("fence_op_finish_single", op_finish, 0);

        // Fence when already idle retires straight from FETCH
        push(1'b1, 2'd1, 64'h0);
        #1 chk("fence_idle_pop", rrequest, 1);
        cyc();
        rready = 1'b0;
        #1 chk("fence_idle_finish", op_finish, 1);
        cyc();
        chk("fence_idle_finish_single", op_finish, 0);

        // Clear with one outstanding on ch1
        issue(2'd1, 64'h42);
        clear_req = 1'b1;
        push(1'b0, 2'd2, 64'h33);
        #1 chk("clear_no_pop0", rrequest, 0);
        cyc();
        #1 chk("clear_no_pop1", rrequest, 0);
        chk("clear_wait_finish", clear_finish, 0);
        efin = 3'b010;
        cyc();
        efin = '0;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            if (clear_finish) seen = 1'b1;
            else cyc();
        end
        chk("clear_finish_seen", seen, 1);
        chk("clear_finish_no_pop", rrequest, 0);
        clear_req = 1'b0;
        rready    = 1'b0;
        cyc();
        chk("clear_finish_single", clear_finish, 0);

        // Reset while an instruction is held in ISSUE
        issue(2'd0, 64'h11);
        wready = 3'b000;
        push(1'b0, 2'd2, 64'h44);
        #1 chk("rstiss_rrequest", rrequest, 1);
        cyc();
        rready = 1'b0;
        #1 chk("rstiss_wvalid", wvalid, 3'b100);
        cyc();
        chk("rstiss_wvalid_hold", wvalid, 3'b100);
        rstnn = 1'b0;
        cyc();
        chk("rstiss_wvalid_cleared", wvalid, 0);
        chk("rstiss_outstanding", outstanding, 0);
        chk("rstiss_all_idle", all_idle, 1);
        rstnn  = 1'b1;
        wready = 3'b111;
        cyc();
        chk("rstiss_no_reissue", wvalid, 0);

`ifdef DCA_MATRIX_LSU_DISPATCH_ERROR_EN
        rstnn = 1'b0; wready = '0;
        cyc();
        rstnn = 1'b1;
        chk("err_reset", error_flags, 0);
        efin = 3'b001;
        cyc();
        efin = '0;
        #1 chk("err_finish_at_zero", error_flags, 3'b001);
        push(1'b0, 2'd3, 64'h5A);
        #1 chk("err_badch_pop", rrequest, 1);
        cyc();
        rready = 1'b0;
        #1 chk("err_badch_flags", error_flags, 3'b011);
        chk("err_badch_wvalid", wvalid, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
